inst_fetch_buffer: RTL and testbench

- Response side of the IF stage: accepts fetch requests (PC values) from the PC register and issues them to a synchronous instruction ROM with 1-cycle read latency.
- Buffers the returned {pc, inst} pairs in a small FIFO and presents them to ID with valid/ready.
- Its req_ready drives the PC register's enable, so it throttles fetch under ID back-pressure.
- flush discards all buffered and in-flight fetches on redirect.

---
 rtl/inst_fetch_buffer_pkg.sv | 24 ++
 rtl/inst_fifo_ram.sv | 27 ++
 rtl/inst_fetch_buffer.sv | 141 ++++++++++++++
 tb/tb_inst_fetch_buffer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_buffer_pkg.sv
// rtl/inst_fetch_buffer_pkg.sv - shared constants and types for the instruction fetch buffer
package inst_fetch_buffer_pkg;

  // Default FIFO depth (power of two, at least 2)
  localparam int          IFB_DEPTH = 4;

  // Instruction presented while the buffer is empty
  localparam logic [31:0] INST_NOP  = 32'h0000_0000;

  // PC register reset constant (first increment lands on 0)
  localparam logic [31:0] PC_RESET  = 32'hffff_fffc;

  // One buffered fetch: the full request PC and the returned instruction
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  // ROM is word addressed; the low PC bits never reach the memory
  function automatic logic [31:0] word_addr(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/inst_fifo_ram.sv
// rtl/inst_fifo_ram.sv - DEPTH x {pc, inst} storage, one sync write port, one comb read port
module inst_fifo_ram
  import inst_fetch_buffer_pkg::*;
#(
  parameter int DEPTH = IFB_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  fetch_entry_t  wdata,
  input  logic [AW-1:0] raddr,
  output fetch_entry_t  rdata
);

  fetch_entry_t mem [DEPTH];

  // Write the returned fetch into its slot; contents need no reset since count gates the reads
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/inst_fetch_buffer.sv
// rtl/inst_fetch_buffer.sv - IF response buffer: ROM issue, credit throttle, flush; optional FETCH_BYPASS_EN
module inst_fetch_buffer
  import inst_fetch_buffer_pkg::*;
#(
  parameter int          DEPTH           = IFB_DEPTH,
  parameter logic [31:0] RESET_PC_EXPECT = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [31:0] req_pc,
  output logic        req_ready,
  output logic        mem_en,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        flush,
  output logic        out_valid,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  input  logic        out_ready
);

  localparam int             AW      = $clog2(DEPTH);
  localparam logic [AW+1:0]  DEPTH_W = (AW+2)'(DEPTH);
  localparam logic [AW:0]    DEPTH_C = (AW+1)'(DEPTH);

  logic [AW:0]   count;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          inflight;
  logic [31:0]   inflight_pc;

  logic [AW+1:0] credit;
  logic          fire;
  logic          push;
  logic          pop;
  logic          fifo_nonempty;
  logic          bypass_take;
  fetch_entry_t  head;
  fetch_entry_t  wr_entry;

  // An accepted fetch reserves a slot until its response lands, so a buffered
  // entry plus the outstanding read can never exceed the FIFO.
  assign credit        = {1'b0, count} + {{(AW+1){1'b0}}, inflight};
  assign req_ready     = !flush && (credit < DEPTH_W);
  assign fire          = req_valid && req_ready;
  assign fifo_nonempty = (count != '0);

  assign mem_en   = fire;
  assign mem_addr = fire ? word_addr(req_pc) : 32'h0000_0000;

`ifdef FETCH_BYPASS_EN
  logic bypass_active;
  assign bypass_active = inflight && !fifo_nonempty && !flush;
  assign bypass_take   = bypass_active && out_ready;
`else
  assign bypass_take   = 1'b0;
`endif

  assign push     = inflight && !flush && !bypass_take;
  assign pop      = fifo_nonempty && out_ready && !flush;
  assign wr_entry = '{pc: inflight_pc, inst: mem_rdata};

  inst_fifo_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (wr_entry),
    .raddr (rd_ptr),
    .rdata (head)
  );

  // Present the head entry, or the live ROM response when bypassing an empty FIFO
  always_comb begin
    out_valid = 1'b0;
    out_pc    = 32'h0000_0000;
    out_inst  = INST_NOP;
    if (fifo_nonempty) begin
      out_valid = 1'b1;
      out_pc    = head.pc;
      out_inst  = head.inst;
    end
`ifdef FETCH_BYPASS_EN
    else if (bypass_active) begin
      out_valid = 1'b1;
      out_pc    = inflight_pc;
      out_inst  = mem_rdata;
    end
`endif
  end

  // Pointer, occupancy and in-flight tracking; flush drops the FIFO and the outstanding read
  always_ff @(posedge clk) begin
    if (!rst) begin
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      inflight    <= 1'b0;
      inflight_pc <= 32'h0000_0000;
    end else if (flush) begin
      count    <= '0;
      rd_ptr   <= wr_ptr;
      inflight <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count    <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      inflight <= fire;
      if (fire) begin
        inflight_pc <= req_pc;
      end
    end
  end

  // Remember that the next accepted fetch is the first one after reset
  logic first_fetch;
  always_ff @(posedge clk) begin
    if (!rst) begin
      first_fetch <= 1'b1;
    end else if (fire) begin
      first_fetch <= 1'b0;
    end
  end

  a_no_write_when_full : assert property (@(posedge clk) disable iff (!rst)
    !(push && count == DEPTH_C));

  a_count_bounded : assert property (@(posedge clk) disable iff (!rst)
    count <= DEPTH_C);

  a_reset_pc : assert property (@(posedge clk) disable iff (!rst)
    (fire && first_fetch) |-> (req_pc == RESET_PC_EXPECT));

endmodule

// File: tb/tb_inst_fetch_buffer.sv
// tb/tb_inst_fetch_buffer.sv - randomized, queue-model-checked bench for inst_fetch_buffer
module tb_inst_fetch_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [31:0] req_pc;
  logic        req_ready;
  logic        mem_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        flush;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        out_ready;

  inst_fetch_buffer #(
    .DEPTH           (DEPTH),
    .RESET_PC_EXPECT (32'h0000_0000)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_pc    (req_pc),
    .req_ready (req_ready),
    .mem_en    (mem_en),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .flush     (flush),
    .out_valid (out_valid),
    .out_pc    (out_pc),
    .out_inst  (out_inst),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return 32'h1000_0000 + {2'b00, a[31:2]};
  endfunction

  // Synchronous ROM, one-cycle read latency
  initial mem_rdata = 32'h0;
  always @(posedge clk) begin
    if (mem_en) mem_rdata <= rom_word(mem_addr);
  end

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  ent_t        mq[$];
  bit          pend;
  logic [31:0] pend_pc;
  bit          need_pc0;
  int          n_cmp;
  int          n_err;
  logic [31:0] next_pc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // One cycle: drive inputs, check outputs against the queue model, advance the model
  task automatic step(input logic r, input logic v, input logic [31:0] pc,
                      input logic fl, input logic ordy, output bit fired);
    bit          exp_ready;
    bit          exp_valid;
    bit          byp;
    logic [31:0] exp_pc;
    logic [31:0] exp_inst;
    int          occ;
    rst       = r;
    req_valid = v;
    req_pc    = (need_pc0 && r) ? 32'h0 : pc;
    flush     = fl;
    out_ready = ordy;
    #1;
    occ       = mq.size() + (pend ? 1 : 0);
    exp_ready = !fl && (occ < DEPTH);
    exp_valid = mq.size() != 0;
    byp       = 1'b0;
    exp_pc    = 32'h0;
    exp_inst  = 32'h0;
    if (exp_valid) begin
      exp_pc   = mq[0].pc;
      exp_inst = mq[0].inst;
    end
`ifdef FETCH_BYPASS_EN
    else if (pend && !fl) begin
      byp       = 1'b1;
      exp_valid = 1'b1;
      exp_pc    = pend_pc;
      exp_inst  = rom_word(pend_pc);
    end
`endif
    fired = v && exp_ready;
    check("req_ready", 32'(req_ready), 32'(exp_ready));
    check("out_valid", 32'(out_valid), 32'(exp_valid));
    if (exp_valid) begin
      check("out_pc", out_pc, exp_pc);
      check("out_inst", out_inst, exp_inst);
    end
    check("mem_en", 32'(mem_en), 32'(fired));
    if (fired) check("mem_addr", mem_addr, req_pc & 32'hffff_fffc);
    if (!r || fl) begin
      mq.delete();
      pend = 1'b0;
      if (!r) begin
        need_pc0 = 1'b1;
        fired    = 1'b0;
      end
    end else begin
      if (mq.size() != 0 && ordy) mq.delete(0);
      if (pend && !(byp && ordy)) mq.push_back('{pc: pend_pc, inst: rom_word(pend_pc)});
      pend    = fired;
      pend_pc = req_pc;
      if (fired) need_pc0 = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic ordy);
    bit f;
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 32'h0, 1'b0, ordy, f);
  endtask

  // PC register behaviour: hold the PC until it is accepted, then advance by 4
  task automatic run_pc(input int n, input logic ordy);
    bit f;
    for (int i = 0; i < n; i++) begin
      step(1'b1, 1'b1, next_pc, 1'b0, ordy, f);
      if (f) next_pc = next_pc + 32'd4;
    end
  endtask

  initial begin
    bit f;
    n_cmp    = 0;
    n_err    = 0;
    pend     = 1'b0;
    pend_pc  = 32'h0;
    need_pc0 = 1'b1;
    rst       = 1'b0;
    req_valid = 1'b0;
    req_pc    = 32'h0;
    flush     = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);

    // Reset, then a three-PC stream with ID always ready
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, f);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, f);
    idle(1, 1'b1);
    next_pc = 32'h0;
    run_pc(3, 1'b1);
    idle(4, 1'b1);

    // Back-pressure: four accepts then stall, then drain in order
    next_pc = 32'h0;
    run_pc(8, 1'b0);
    run_pc(8, 1'b1);
    idle(6, 1'b1);

    // Flush with a fetch in flight
    step(1'b1, 1'b1, 32'h20, 1'b0, 1'b1, f);
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, f);
    idle(3, 1'b1);

    // Full FIFO with simultaneous push and pop, pointers wrapping
    next_pc = 32'h100;
    run_pc(5, 1'b0);
    run_pc(12, 1'b1);
    idle(6, 1'b1);

    // Reset mid-stream with entries buffered
    next_pc = 32'h200;
    run_pc(4, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, f);
    next_pc = 32'h0;
    run_pc(3, 1'b1);
    idle(4, 1'b1);

    // Empty FIFO, single fetch with ID ready (bypass case when enabled)
    step(1'b1, 1'b1, 32'h40, 1'b0, 1'b1, f);
    idle(3, 1'b1);
    step(1'b1, 1'b1, 32'h43, 1'b0, 1'b0, f);
    idle(3, 1'b1);

    // Randomized traffic: unaligned PCs, bursty ready, occasional flush and reset
    for (int i = 0; i < 1500; i++) begin
      logic        r;
      logic        v;
      logic        fl;
      logic        ordy;
      logic [31:0] pc;
      r    = ($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1;
      v    = ($urandom_range(0, 3) != 0);
      fl   = ($urandom_range(0, 19) == 0);
      ordy = ($urandom_range(0, 2) != 0);
      pc   = 32'($urandom_range(0, 4095));
      step(r, v, pc, fl, ordy, f);
    end
    idle(6, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
